// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter sharing the memory request port between icache and dcache.
// Locks each grant until the downstream ack and routes returns back by tid.
module wt_mem_arbiter #(
  parameter int ReqWidth       = 128,
  parameter int RtrnWidth      = 192,
  parameter int TidWidth       = 2,
  parameter int TidLsb         = 0,
  parameter int MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 ic_req_i,
  input  logic [ReqWidth-1:0]  ic_data_i,
  output logic                 ic_ack_o,
  input  logic                 dc_req_i,
  input  logic [ReqWidth-1:0]  dc_data_i,
  output logic                 dc_ack_o,
  output logic                 mem_req_o,
  output logic [ReqWidth-1:0]  mem_data_o,
  input  logic                 mem_ack_i,
  input  logic                 mem_rtrn_vld_i,
  input  logic [TidWidth-1:0]  mem_rtrn_tid_i,
  input  logic [RtrnWidth-1:0] mem_rtrn_i,
  output logic                 ic_rtrn_vld_o,
  output logic                 dc_rtrn_vld_o,
  output logic [RtrnWidth-1:0] rtrn_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int NumTid = 2 ** TidWidth;
  localparam int CntW   = $clog2(MaxOutstanding + 1);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e              r_state, w_stateNext;
  logic                r_gnt, w_gntNext;
  logic                r_prio;
  logic                r_err;
  logic                r_clrPend;
  logic [CntW-1:0]     r_icCnt, r_dcCnt;
  logic [NumTid-1:0]   r_tblVld, r_tblSrc;

  logic                w_tblFull, w_icElig, w_dcElig;
  logic                w_ack, w_doClr;
  logic [ReqWidth-1:0] w_reqData;
  logic [TidWidth-1:0] w_ackTid;
  logic                w_rtrnHit, w_rtrnMiss, w_rtrnSrc;
  logic                w_ackOverwrite;
  logic                w_icInc, w_icDec, w_dcInc, w_dcDec;

  // Source encoding for r_gnt, r_prio and the table: 0 = icache, 1 = dcache.
  assign w_tblFull  = &r_tblVld;
  assign w_icElig   = ic_req_i && (r_icCnt < CntW'(MaxOutstanding)) && !w_tblFull;
  assign w_dcElig   = dc_req_i && (r_dcCnt < CntW'(MaxOutstanding)) && !w_tblFull;
  assign w_ack      = (r_state == LOCK) && mem_ack_i;
  assign w_reqData  = r_gnt ? dc_data_i : ic_data_i;
  assign w_ackTid   = w_reqData[TidLsb +: TidWidth];
  assign w_rtrnHit  = mem_rtrn_vld_i && r_tblVld[mem_rtrn_tid_i];
  assign w_rtrnMiss = mem_rtrn_vld_i && !r_tblVld[mem_rtrn_tid_i];
  assign w_rtrnSrc  = r_tblSrc[mem_rtrn_tid_i];
  assign w_doClr    = ((r_state == IDLE) && clr_i) || (w_ack && (r_clrPend || clr_i));
  assign w_ackOverwrite = w_ack && r_tblVld[w_ackTid] &&
                          !(w_rtrnHit && (mem_rtrn_tid_i == w_ackTid));

  always_comb begin
    w_stateNext = r_state;
    w_gntNext   = r_gnt;
    case (r_state)
      IDLE: begin
        if (!clr_i) begin
          if (w_icElig && w_dcElig) begin
            w_gntNext   = r_prio;
            w_stateNext = LOCK;
          end else if (w_icElig) begin
            w_gntNext   = 1'b0;
            w_stateNext = LOCK;
          end else if (w_dcElig) begin
            w_gntNext   = 1'b1;
            w_stateNext = LOCK;
          end
        end
      end
      LOCK: begin
        if (mem_ack_i) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign mem_req_o     = (r_state == LOCK);
  assign mem_data_o    = (r_state == LOCK) ? w_reqData : '0;
  assign ic_ack_o      = w_ack && !r_gnt;
  assign dc_ack_o      = w_ack && r_gnt;
  assign ic_rtrn_vld_o = w_rtrnHit && !w_rtrnSrc;
  assign dc_rtrn_vld_o = w_rtrnHit && w_rtrnSrc;
  assign rtrn_o        = mem_rtrn_i;
  assign busy_o        = (r_state == LOCK) || (r_icCnt != '0) || (r_dcCnt != '0);
  assign err_o         = r_err;

  assign w_icInc = ic_ack_o;
  assign w_icDec = ic_rtrn_vld_o;
  assign w_dcInc = dc_ack_o;
  assign w_dcDec = dc_rtrn_vld_o;

  // A deferred clear lands on the ack edge and overrides that ack's bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_gnt     <= 1'b0;
      r_prio    <= 1'b0;
      r_err     <= 1'b0;
      r_clrPend <= 1'b0;
      r_icCnt   <= '0;
      r_dcCnt   <= '0;
      r_tblVld  <= '0;
      r_tblSrc  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_gnt   <= w_gntNext;
      if (w_doClr) begin
        r_prio    <= 1'b0;
        r_err     <= 1'b0;
        r_clrPend <= 1'b0;
        r_icCnt   <= '0;
        r_dcCnt   <= '0;
        r_tblVld  <= '0;
        r_tblSrc  <= '0;
      end else begin
        if (w_icInc && !w_icDec) r_icCnt <= r_icCnt + CntW'(1);
        else if (w_icDec && !w_icInc) r_icCnt <= r_icCnt - CntW'(1);
        if (w_dcInc && !w_dcDec) r_dcCnt <= r_dcCnt + CntW'(1);
        else if (w_dcDec && !w_dcInc) r_dcCnt <= r_dcCnt - CntW'(1);
        // Clear first so a same-tid allocation in this cycle takes precedence.
        if (w_rtrnHit) r_tblVld[mem_rtrn_tid_i] <= 1'b0;
        if (w_ack) begin
          r_tblVld[w_ackTid] <= 1'b1;
          r_tblSrc[w_ackTid] <= r_gnt;
          r_prio             <= ~r_gnt;
        end
        if (w_rtrnMiss || w_ackOverwrite) r_err <= 1'b1;
        if ((r_state == LOCK) && clr_i && !mem_ack_i) r_clrPend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Directed bench for wt_mem_arbiter: a per-cycle vector table followed by
// hand-written sequences for clear-in-lock, outstanding cap, same-cycle ack/return and reset.
module tb_wt_mem_arbiter;

  logic         clock = 1'b0;
  logic         rstN;
  logic         clrI;
  logic         icReq, dcReq, icAck, dcAck;
  logic [127:0] icData, dcData, memData;
  logic         memReq, memAck;
  logic         rtrnVld;
  logic [1:0]   rtrnTid;
  logic [191:0] memRtrn, rtrnOut;
  logic         icRv, dcRv, busy, err;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clock = ~clock;

  wt_mem_arbiter dut (
    .clk_i(clock), .rst_ni(rstN), .clr_i(clrI),
    .ic_req_i(icReq), .ic_data_i(icData), .ic_ack_o(icAck),
    .dc_req_i(dcReq), .dc_data_i(dcData), .dc_ack_o(dcAck),
    .mem_req_o(memReq), .mem_data_o(memData), .mem_ack_i(memAck),
    .mem_rtrn_vld_i(rtrnVld), .mem_rtrn_tid_i(rtrnTid), .mem_rtrn_i(memRtrn),
    .ic_rtrn_vld_o(icRv), .dc_rtrn_vld_o(dcRv), .rtrn_o(rtrnOut),
    .busy_o(busy), .err_o(err)
  );

  typedef struct {
    logic       icReq; logic [1:0] icTid;
    logic       dcReq; logic [1:0] dcTid;
    logic       memAck;
    logic       rVld;  logic [1:0] rTid;
    logic       clr;
    logic       eMemReq; logic [1:0] eSrc; logic [1:0] eMemTid;
    logic       eIcAck, eDcAck, eIcRv, eDcRv, eBusy, eErr;
  } vec_t;

  vec_t vecs [25];

  function automatic logic [127:0] pay(input bit isDc, input logic [1:0] tid);
    return {(isDc ? 8'hDC : 8'hC1), 118'd0, tid};
  endfunction

  function automatic logic [191:0] rtrnPat(input int idx);
    return {64'hFEED_0000_BEEF_0000, 96'd0, 32'(idx)};
  endfunction

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    icReq   = v.icReq;  icData = pay(1'b0, v.icTid);
    dcReq   = v.dcReq;  dcData = pay(1'b1, v.dcTid);
    memAck  = v.memAck;
    rtrnVld = v.rVld;   rtrnTid = v.rTid;
    clrI    = v.clr;
    memRtrn = rtrnPat(idx);
  endtask

  task automatic idleInputs();
    icReq = 0; dcReq = 0; memAck = 0; rtrnVld = 0; rtrnTid = 0; clrI = 0;
  endtask

  // Request from one source and ack it as soon as it reaches the memory port.
  task automatic issue(input bit isDc, input logic [1:0] tid);
    int waitCnt;
    waitCnt = 0;
    @(negedge clock);
    idleInputs();
    if (isDc) begin dcReq = 1; dcData = pay(1'b1, tid); end
    else begin icReq = 1; icData = pay(1'b0, tid); end
    #1;
    while (!memReq && waitCnt < 10) begin
      @(negedge clock); #1;
      waitCnt++;
    end
    checkOutput("issue_memReq", 192'(memReq), 192'(1));
    checkOutput("issue_memData", 192'(memData), 192'(pay(isDc, tid)));
    memAck = 1; #1;
    checkOutput(isDc ? "issue_dcAck" : "issue_icAck", 192'(isDc ? dcAck : icAck), 192'(1));
    @(negedge clock);
    idleInputs();
  endtask

  task automatic returnTid(input logic [1:0] tid, input bit isDc);
    @(negedge clock);
    idleInputs();
    rtrnVld = 1; rtrnTid = tid; #1;
    checkOutput("ret_icRv", 192'(icRv), 192'(!isDc));
    checkOutput("ret_dcRv", 192'(dcRv), 192'(isDc));
    @(negedge clock);
    idleInputs();
  endtask

  initial begin
    // icReq,icTid,dcReq,dcTid,memAck,rVld,rTid,clr | eMemReq,eSrc,eMemTid,eIcAck,eDcAck,eIcRv,eDcRv,eBusy,eErr
    vecs[0]  = '{1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0};
    vecs[1]  = '{1,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,1,0};
    vecs[2]  = '{1,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,1,0};
    vecs[3]  = '{1,0,0,0,0,0,0,0, 1,1,0,0,0,0,0,1,0};
    vecs[4]  = '{1,0,0,0,1,0,0,0, 1,1,0,1,0,0,0,1,0};
    vecs[5]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,0};
    vecs[6]  = '{0,0,0,0,0,1,0,0, 0,0,0,0,0,1,0,1,0};
    vecs[7]  = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0};
    vecs[8]  = '{0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,0};
    vecs[9]  = '{1,0,1,1,0,0,0,0, 0,0,0,0,0,0,0,0,0};
    vecs[10] = '{1,0,1,1,1,0,0,0, 1,1,0,1,0,0,0,1,0};
    vecs[11] = '{1,2,1,1,0,0,0,0, 0,0,0,0,0,0,0,1,0};
    vecs[12] = '{1,2,1,1,1,0,0,0, 1,2,1,0,1,0,0,1,0};
    vecs[13] = '{1,2,1,3,0,0,0,0, 0,0,0,0,0,0,0,1,0};
    vecs[14] = '{1,2,1,3,1,0,0,0, 1,1,2,1,0,0,0,1,0};
    vecs[15] = '{0,0,1,3,0,0,0,0, 0,0,0,0,0,0,0,1,0};
    vecs[16] = '{0,0,1,3,1,0,0,0, 1,2,3,0,1,0,0,1,0};
    vecs[17] = '{0,0,0,0,0,1,1,0, 0,0,0,0,0,0,1,1,0};
    vecs[18] = '{0,0,0,0,0,1,2,0, 0,0,0,0,0,1,0,1,0};
    vecs[19] = '{0,0,0,0,0,1,3,0, 0,0,0,0,0,0,1,1,0};
    vecs[20] = '{0,0,0,0,0,1,0,0, 0,0,0,0,0,1,0,1,0};
    vecs[21] = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0};
    vecs[22] = '{0,0,0,0,0,1,3,0, 0,0,0,0,0,0,0,0,0};
    vecs[23] = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1};
    vecs[24] = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1};

    rstN = 0; idleInputs(); icData = '0; dcData = '0; memRtrn = '0;
    repeat (2) @(negedge clock);
    #1;
    checkOutput("rst_memReq", 192'(memReq), 192'(0));
    checkOutput("rst_memData", 192'(memData), 192'(0));
    checkOutput("rst_busy", 192'(busy), 192'(0));
    checkOutput("rst_err", 192'(err), 192'(0));
    checkOutput("rst_acks", 192'({icAck, dcAck, icRv, dcRv}), 192'(0));
    @(negedge clock);
    rstN = 1;

    // One row per clock cycle, driven and checked in the low phase.
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      applyStimulus(vecs[i], i);
      #1;
      checkOutput($sformatf("v%0d_memReq", i), 192'(memReq), 192'(vecs[i].eMemReq));
      checkOutput($sformatf("v%0d_memData", i), 192'(memData),
                  192'((vecs[i].eSrc == 0) ? 128'd0 : pay(vecs[i].eSrc == 2, vecs[i].eMemTid)));
      checkOutput($sformatf("v%0d_icAck", i), 192'(icAck), 192'(vecs[i].eIcAck));
      checkOutput($sformatf("v%0d_dcAck", i), 192'(dcAck), 192'(vecs[i].eDcAck));
      checkOutput($sformatf("v%0d_icRv", i), 192'(icRv), 192'(vecs[i].eIcRv));
      checkOutput($sformatf("v%0d_dcRv", i), 192'(dcRv), 192'(vecs[i].eDcRv));
      checkOutput($sformatf("v%0d_busy", i), 192'(busy), 192'(vecs[i].eBusy));
      checkOutput($sformatf("v%0d_err", i), 192'(err), 192'(vecs[i].eErr));
      checkOutput($sformatf("v%0d_rtrn", i), rtrnOut, rtrnPat(i));
    end

    // Clear raised while locked is held off until the ack, then wipes state and err.
    @(negedge clock); idleInputs(); icReq = 1; icData = pay(1'b0, 2'd0); #1;
    checkOutput("clr_preLock", 192'(memReq), 192'(0));
    @(negedge clock); clrI = 1; #1;
    checkOutput("clr_locked", 192'(memReq), 192'(1));
    @(negedge clock); clrI = 0; #1;
    checkOutput("clr_stillLocked", 192'(memReq), 192'(1));
    @(negedge clock); memAck = 1; #1;
    checkOutput("clr_ackDone", 192'(icAck), 192'(1));
    checkOutput("clr_errBefore", 192'(err), 192'(1));
    @(negedge clock); idleInputs(); #1;
    checkOutput("clr_busy", 192'(busy), 192'(0));
    checkOutput("clr_err", 192'(err), 192'(0));
    checkOutput("clr_icCnt", 192'(dut.r_icCnt), 192'(0));
    @(negedge clock); icReq = 1; clrI = 1; #1;
    @(negedge clock); idleInputs(); #1;
    checkOutput("clr_noGrant", 192'(memReq), 192'(0));

    // Outstanding cap: four dc transactions fill both the counter and the table.
    issue(1'b1, 2'd1); issue(1'b1, 2'd2); issue(1'b1, 2'd3); issue(1'b1, 2'd0);
    checkOutput("cap_dcCnt4", 192'(dut.r_dcCnt), 192'(4));
    @(negedge clock); dcReq = 1; dcData = pay(1'b1, 2'd2); icReq = 1; icData = pay(1'b0, 2'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); #1;
      checkOutput($sformatf("cap_blocked%0d", k), 192'(memReq), 192'(0));
    end
    @(negedge clock); icReq = 0; rtrnVld = 1; rtrnTid = 2; #1;
    checkOutput("cap_retDcRv", 192'(dcRv), 192'(1));
    @(negedge clock); rtrnVld = 0; #1;
    checkOutput("cap_dcCnt3", 192'(dut.r_dcCnt), 192'(3));
    checkOutput("cap_grantPending", 192'(memReq), 192'(0));
    @(negedge clock); #1;
    checkOutput("cap_regrant", 192'(memReq), 192'(1));
    checkOutput("cap_regrantData", 192'(memData), 192'(pay(1'b1, 2'd2)));
    memAck = 1; #1;
    checkOutput("cap_regrantAck", 192'(dcAck), 192'(1));
    @(negedge clock); idleInputs(); #1;
    checkOutput("cap_dcCntBack4", 192'(dut.r_dcCnt), 192'(4));
    returnTid(2'd1, 1'b1); returnTid(2'd3, 1'b1); returnTid(2'd0, 1'b1); returnTid(2'd2, 1'b1);
    #1;
    checkOutput("cap_drained", 192'(busy), 192'(0));
    checkOutput("cap_noErr", 192'(err), 192'(0));

    // Same-cycle ack and return on dcache at count 2.
    issue(1'b1, 2'd0); issue(1'b1, 2'd1);
    checkOutput("sc_dcCnt2pre", 192'(dut.r_dcCnt), 192'(2));
    @(negedge clock); dcReq = 1; dcData = pay(1'b1, 2'd2);
    @(negedge clock); #1;
    checkOutput("sc_locked", 192'(memReq), 192'(1));
    memAck = 1; rtrnVld = 1; rtrnTid = 0; #1;
    checkOutput("sc_dcAck", 192'(dcAck), 192'(1));
    checkOutput("sc_dcRv", 192'(dcRv), 192'(1));
    @(negedge clock); idleInputs(); #1;
    checkOutput("sc_dcCnt2", 192'(dut.r_dcCnt), 192'(2));
    checkOutput("sc_tbl2Valid", 192'(dut.r_tblVld[2]), 192'(1));
    checkOutput("sc_tbl0Clear", 192'(dut.r_tblVld[0]), 192'(0));
    checkOutput("sc_noErr", 192'(err), 192'(0));
    returnTid(2'd1, 1'b1); returnTid(2'd2, 1'b1);
    #1;
    checkOutput("sc_drained", 192'(busy), 192'(0));

    // Reset in the middle of a lock drops the memory request at once.
    @(negedge clock); icReq = 1; icData = pay(1'b0, 2'd3);
    @(negedge clock); #1;
    checkOutput("rl_locked", 192'(memReq), 192'(1));
    rstN = 0; #1;
    checkOutput("rl_dropped", 192'(memReq), 192'(0));
    @(negedge clock); idleInputs(); rstN = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
